// File: rtl/sdm_dec_pkg.sv
// -----------------------------------------------------------------------------
// sdm_dec_pkg
// Shared constants and width helpers for the sigma-delta bitstream decimator.
//   CIC_ORDER      : number of integrator / comb stages
//   OUT_W          : PCM output width
//   cic_width()    : register width that holds R^3 without loss (3*log2r + 1)
//   cic_out_shift(): right shift that maps the raw comb result onto OUT_W bits
// -----------------------------------------------------------------------------
package sdm_dec_pkg;

  localparam int CIC_ORDER      = 3;
  localparam int OUT_W          = 16;
  localparam int LOG2_DECIM_MIN = 6;
  localparam int LOG2_DECIM_MAX = 10;

  // Width needed for integrators and comb delays; modulo-2^W wrap is harmless
  // because the comb differences recover the exact result.
  function automatic int cic_width(input int log2r);
    return CIC_ORDER * log2r + 1;
  endfunction

  // Raw result spans [0, R^3] = [0, 2^(3*log2r)]; drop the low bits so the
  // top of the range lands just above the 16-bit full scale (then saturates).
  function automatic int cic_out_shift(input int log2r);
    return CIC_ORDER * log2r - OUT_W;
  endfunction

endpackage

// File: rtl/sdm_cic_comb.sv
// -----------------------------------------------------------------------------
// sdm_cic_comb
// One CIC comb stage: comb_out = comb_in - previous comb_in (sampled on step).
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset (delay register -> 0)
//   step     in  decimated-rate strobe; advances the delay register
//   comb_in  in  W-bit stage input
//   comb_out out W-bit stage output (combinational difference, wraps mod 2^W)
// -----------------------------------------------------------------------------
module sdm_cic_comb
  import sdm_dec_pkg::*;
#(
  parameter int W = cic_width(6)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic [W-1:0] comb_in,
  output logic [W-1:0] comb_out
);

  logic [W-1:0] dly_r;

  // Delay register: remembers this stage's input from the previous strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_r <= {W{1'b0}};
    end else if (step) begin
      dly_r <= comb_in;
    end
  end

  assign comb_out = comb_in - dly_r;

endmodule

// File: rtl/sdm_decimator.sv
// -----------------------------------------------------------------------------
// sdm_decimator
// Converts a 1-bit delta-sigma bitstream into 16-bit unsigned PCM using a
// 3rd-order CIC decimator with ratio R = 2^LOG2_DECIM (LOG2_DECIM in 6..10).
// Samples leave through a valid/ready register with a sticky overrun flag.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   consume one bitstream bit this cycle; low = filter holds
//   sd_in        in   bitstream (1 -> +1, 0 -> 0)
//   out_data     out  16-bit PCM sample
//   out_valid    out  out_data holds an unconsumed sample
//   out_ready    in   consumer accepts when out_valid && out_ready
//   overrun      out  sticky: a sample was overwritten before being taken
//   clr_overrun  in   synchronous clear of overrun (a same-cycle set wins)
//
// Build option SDM_DEC_INPUT_SYNC_EN:
//   defined   - sd_in passes a 2-flop synchronizer (free-running on clk).
//               The two reset-zero synchronizer outputs are not fed to the
//               filter, so the first sample arrives R+2 cycles after reset.
//   undefined - sd_in feeds the first integrator directly (same clock domain).
// -----------------------------------------------------------------------------
module sdm_decimator
  import sdm_dec_pkg::*;
#(
  parameter int LOG2_DECIM = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sd_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int W     = cic_width(LOG2_DECIM);
  localparam int SHIFT = cic_out_shift(LOG2_DECIM);

  logic                  x_s;
  logic                  en_eff_s;
  logic                  strobe_s;
  logic [LOG2_DECIM-1:0] cnt_r;
  logic [W-1:0]          i1_r;
  logic [W-1:0]          i2_r;
  logic [W-1:0]          i3_r;
  logic [W-1:0]          c1_s;
  logic [W-1:0]          c2_s;
  logic [W-1:0]          c3_s;
  logic [W-1:0]          shifted_s;
  logic [OUT_W-1:0]      sample_s;
  logic                  handshake_s;
  logic                  overrun_set_s;
  logic [OUT_W-1:0]      out_data_r;
  logic                  out_valid_r;
  logic                  overrun_r;

`ifdef SDM_DEC_INPUT_SYNC_EN
  logic       sync1_r;
  logic       sync2_r;
  logic [1:0] prime_r;

  // Two-flop synchronizer plus a fill counter; the filter only starts once
  // real input bits have reached the second flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prime_r <= 2'd0;
    end else begin
      sync1_r <= sd_in;
      sync2_r <= sync1_r;
      if (prime_r != 2'd2) begin
        prime_r <= prime_r + 2'd1;
      end
    end
  end

  assign x_s      = sync2_r;
  assign en_eff_s = en && (prime_r == 2'd2);
`else
  assign x_s      = sd_in;
  assign en_eff_s = en;
`endif

  // The R-th consumed bit of each frame is the decimation point.
  assign strobe_s = en_eff_s && (cnt_r == {LOG2_DECIM{1'b1}});

  // Integrator cascade and frame counter; each stage adds the previous
  // stage's old value, which is what delays the strobe-cycle bit into the
  // next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_r  <= {W{1'b0}};
      i2_r  <= {W{1'b0}};
      i3_r  <= {W{1'b0}};
      cnt_r <= {LOG2_DECIM{1'b0}};
    end else if (en_eff_s) begin
      i1_r  <= i1_r + {{(W-1){1'b0}}, x_s};
      i2_r  <= i2_r + i1_r;
      i3_r  <= i3_r + i2_r;
      cnt_r <= cnt_r + {{(LOG2_DECIM-1){1'b0}}, 1'b1};
    end
  end

  sdm_cic_comb #(.W(W)) u_comb1 (
    .clk      (clk),
    .rst      (rst),
    .step     (strobe_s),
    .comb_in  (i3_r),
    .comb_out (c1_s)
  );

  sdm_cic_comb #(.W(W)) u_comb2 (
    .clk      (clk),
    .rst      (rst),
    .step     (strobe_s),
    .comb_in  (c1_s),
    .comb_out (c2_s)
  );

  sdm_cic_comb #(.W(W)) u_comb3 (
    .clk      (clk),
    .rst      (rst),
    .step     (strobe_s),
    .comb_in  (c2_s),
    .comb_out (c3_s)
  );

  // Scale the raw result to 16 bits; only the full-scale value R^3 overflows.
  always_comb begin
    shifted_s = c3_s >> SHIFT;
    if (|shifted_s[W-1:OUT_W]) begin
      sample_s = 16'hFFFF;
    end else begin
      sample_s = shifted_s[OUT_W-1:0];
    end
  end

  assign handshake_s   = out_valid_r && out_ready;
  assign overrun_set_s = strobe_s && out_valid_r && !out_ready;

  // Output register: a new sample always loads; a handshake without a new
  // sample retires the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (strobe_s) begin
      out_data_r  <= sample_s;
      out_valid_r <= 1'b1;
    end else if (handshake_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky overrun flag; a lost sample in the clear cycle keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else if (clr_overrun) begin
      overrun_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sdm_decimator.sv
// -----------------------------------------------------------------------------
// tb_sdm_decimator
// Directed bench for sdm_decimator at LOG2_DECIM = 6 (R = 64, shift = 2).
// Hand-derived values with constant-1 input after reset:
//   output 1 raw = C(63,3)              = 39711  -> 16'h26C7
//   output 2 raw = C(127,3) - 3*C(63,3) = 214242 -> 16'hD138
//   output 3 raw = 2^18 - 1, later 2^18         -> 16'hFFFF
// Alternating 1,0 input settles at raw 2^17 -> 16'h8000 from output 3.
// -----------------------------------------------------------------------------
module tb_sdm_decimator;

  localparam int R = 64;
`ifdef SDM_DEC_INPUT_SYNC_EN
  localparam int LAT0 = R + 2;
`else
  localparam int LAT0 = R;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sd_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clr_overrun;

  int tests_run    = 0;
  int tests_failed = 0;
  bit alt_mode     = 1'b0;
  int cyc;

  always #5 clk = ~clk;

  sdm_decimator #(.LOG2_DECIM(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sd_in       (sd_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (alt_mode) sd_in = ~sd_in;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 300);
    chk("valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic do_reset();
    alt_mode    = 1'b0;
    rst         = 1'b1;
    en          = 1'b0;
    sd_in       = 1'b0;
    clr_overrun = 1'b0;
    steps(2);
  endtask

  task automatic release_rst(input logic sd);
    sd_in = sd;
    en    = 1'b1;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sd_in = 1'b0; out_ready = 1'b1; clr_overrun = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);

    // Constant 1, out_ready high
    out_ready = 1'b1;
    release_rst(1'b1);
    wait_valid(cyc);
    chk("a_lat0", cyc, LAT0);
    chk("a_out1", {16'd0, out_data}, 32'h26C7);
    wait_valid(cyc);
    chk("a_gap2", cyc, R);
    chk("a_out2", {16'd0, out_data}, 32'hD138);
    for (int k = 3; k <= 5; k++) begin
      wait_valid(cyc);
      chk("a_gap", cyc, R);
      chk("a_full", {16'd0, out_data}, 32'hFFFF);
    end
    chk("a_ovr", {31'd0, overrun}, 32'd0);

    // Constant 0
    do_reset();
    release_rst(1'b0);
    for (int k = 1; k <= 4; k++) begin
      wait_valid(cyc);
      chk("b_zero", {16'd0, out_data}, 32'd0);
    end
    chk("b_ovr", {31'd0, overrun}, 32'd0);

    // Alternating 1,0 starting with 1
    do_reset();
    release_rst(1'b1);
    alt_mode = 1'b1;
    wait_valid(cyc);
    wait_valid(cyc);
    for (int k = 3; k <= 5; k++) begin
      wait_valid(cyc);
      chk("c_half", {16'd0, out_data}, 32'h8000);
    end
    alt_mode = 1'b0;

    // Overrun, handshake, clear, set-wins, same-cycle load+handshake
    do_reset();
    out_ready = 1'b0;
    release_rst(1'b1);
    wait_valid(cyc);
    chk("d_lat0", cyc, LAT0);
    chk("d_out1", {16'd0, out_data}, 32'h26C7);
    chk("d_ovr0", {31'd0, overrun}, 32'd0);
    steps(R - 1);
    chk("d_ovr_pre", {31'd0, overrun}, 32'd0);
    chk("d_hold_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("d_ovr_set", {31'd0, overrun}, 32'd1);
    chk("d_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("d_newest", {16'd0, out_data}, 32'hD138);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("d_hs_drop", {31'd0, out_valid}, 32'd0);
    chk("d_ovr_sticky", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("d_clr", {31'd0, overrun}, 32'd0);
    steps(R - 2);
    chk("d_out3_valid", {31'd0, out_valid}, 32'd1);
    chk("d_out3_ovr", {31'd0, overrun}, 32'd0);
    chk("d_out3", {16'd0, out_data}, 32'hFFFF);
    steps(R - 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("d_set_wins", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("d_clr2", {31'd0, overrun}, 32'd0);
    steps(R - 2);
    out_ready = 1'b1;
    step();
    chk("d_load_hs_valid", {31'd0, out_valid}, 32'd1);
    chk("d_load_hs_ovr", {31'd0, overrun}, 32'd0);
    step();
    chk("d_load_hs_drop", {31'd0, out_valid}, 32'd0);

    // en low for 100 cycles mid-frame
    do_reset();
    out_ready = 1'b1;
    release_rst(1'b1);
    for (int k = 1; k <= 3; k++) wait_valid(cyc);
    steps(10);
    en = 1'b0;
    steps(100);
    chk("e_no_valid", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    wait_valid(cyc);
    chk("e_gap", cyc, R - 10);
    chk("e_data", {16'd0, out_data}, 32'hFFFF);

    // Asynchronous reset mid-frame with a pending sample
    do_reset();
    out_ready = 1'b0;
    release_rst(1'b1);
    wait_valid(cyc);
    steps(20);
    #2 rst = 1'b1;
    #1;
    chk("f_async_valid", {31'd0, out_valid}, 32'd0);
    chk("f_async_data", {16'd0, out_data}, 32'd0);
    chk("f_async_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    release_rst(1'b1);
    wait_valid(cyc);
    chk("f_lat0", cyc, LAT0);
    chk("f_out1", {16'd0, out_data}, 32'h26C7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
